jt49_eg_sched: RTL and testbench
================================

// Module: jt49_eg_sched
// PURPOSE
// - Envelope scheduler in front of the envelope generator: owns envelope registers R11/R12 (period) and R13 (shape).
// - Divides the core clock enable by the programmed period and produces the generator's step square wave and null_period flag.
// - Sequences the shape-write restart handshake so the generator sees exactly one restart pulse per R13 write, aligned to cen.
// PARAMETERS
// - PW     16  envelope period width (R12:R11); 8 <= PW <= 16
// - PRESC  1   extra cen divider before period counter; 1 = none, 2 = halve tick rate
// PORTS
// - clk          in   1   core clock (divided-down clock shared with envelope generator)
// - rst_n        in   1   asynchronous reset, active low
// - cen          in   1   clock enable; all state except write capture advances only when high
// - wr_n         in   1   register write strobe, active low, sampled every clk (not gated by cen)
// - addr         in   4   register address (11=fine, 12=coarse, 13=shape)
// - din          in   8   write data
// - dout         out  8   readback data (see CONFIGURATION)
// - step         out  1   square wave to generator; envelope advances on its rising edge
// - null_period  out  1   high while programmed period is 0
// - restart      out  1   restart request, one clk wide, set in a cen cycle
// - ctrl         out  4   shape bits {CONT,ATT,ALT,HOLD} = R13[3:0]
// BEHAVIOUR
// - Reset: period=0, ctrl=4'h0, step=0, null_period=1, restart=0, dout=0, counter=0, prescaler=0, FSM=IDLE.
// - Writes: on clk with wr_n=0, addr 11 -> period[7:0], addr 12 -> period[PW-1:8] (din bits above PW ignored), addr 13 -> ctrl=din[3:0] and restart request; other addrs ignored. Registers update the following clk edge regardless of cen.
// - null_period = (period==0), registered, valid one clk after the write.
// - Tick: tick = cen && (prescaler==PRESC-1); prescaler wraps at PRESC-1 on cen.
// - Counter (PW bits): on tick, if cnt >= period-1 (or period<=1) then cnt<=0 and step<=~step, else cnt<=cnt+1.
//   Result: one step rising edge every 2*period*PRESC cen cycles; period 0 and 1 both toggle every tick.
// - Period rewritten below current cnt: compare is >=, so counter wraps on next tick; no 2^PW rollover.
// - Restart FSM (states IDLE, PEND, FIRE):
//   IDLE -> PEND on R13 write.
//   PEND -> FIRE on first clk with cen=1 (restart=1 for this clk only, registered), cnt<=0, prescaler<=0, step<=0.
//   FIRE -> IDLE next clk; if another R13 write arrived in PEND or FIRE -> PEND (no write lost, pulses never merge).
//   R13 write same clk as FIRE counter clear: clear wins, new request queued in PEND.
// - Tick coinciding with restart clear: clear wins, step stays 0.
// - rst_n low mid-operation: immediate return to reset values; pending restart discarded.
// - Latency: R13 write -> restart high = 1 clk + wait for cen (min 1 clk when cen tied high).
// CONFIGURATION
// - Macro JT49_EG_READBACK_EN:
//   defined: dout registered, 1 clk after address change: 11 -> period[7:0], 12 -> zero-extended period[PW-1:8], 13 -> {4'b0,ctrl}, else 8'h00.
//   undefined: dout tied 8'h00, no readback mux.
// STRUCTURE
// - Shared package jt49_pkg: localparams JT49_REG_EFINE=4'd11, JT49_REG_ECOARSE=4'd12, JT49_REG_ESHAPE=4'd13; typedef of restart FSM state enum {IDLE,PEND,FIRE}.
// - One sub-module jt49_eg_cnt: prescaler + period counter + step toggle, inputs cen, period, clr; outputs step.
// - Top holds register file, null_period, restart FSM, readback mux.
// TESTING
// - Reset: rst_n=0 -> step=0, restart=0, ctrl=0, null_period=1, dout=0; release, cen=1, no writes -> step toggles every cen.
// - Period: write R11=8'h04,R12=8'h00, cen=1, PRESC=1 -> step rising edges exactly 8 clk apart; null_period=0.
// - Restart: write R13=8'h0E with cen=0 for 5 clk -> restart stays 0, fires 1 clk on first cen=1, step and cnt cleared.
// - Back-to-back R13 writes on consecutive clk, cen=1 -> two distinct 1-clk restart pulses, ctrl = second value.
// - Shrink: period=100, wait until cnt=60, write period=10 -> step toggles on next tick, then every 10 ticks.
// - JT49_EG_READBACK_EN defined: write R12=8'hA5 with PW=12 -> dout on addr 12 = 8'h05; undefined -> dout=0 always.

Source files
------------

// File: rtl/jt49_pkg.sv
// Shared JT49 definitions: envelope register addresses and the restart sequencer state type.
package jt49_pkg;

  localparam logic [3:0] JT49_REG_EFINE   = 4'd11;
  localparam logic [3:0] JT49_REG_ECOARSE = 4'd12;
  localparam logic [3:0] JT49_REG_ESHAPE  = 4'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    FIRE = 2'd2
  } jt49_eg_st_e;

endpackage

// File: rtl/jt49_eg_cnt.sv
// Envelope period divider: optional cen prescaler, period counter and step square wave.
module jt49_eg_cnt #(
  parameter int PW    = 16,
  parameter int PRESC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [PW-1:0] period,
  input  logic          clr,
  output logic          step
);

  localparam int PSW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PSW-1:0] PSC_LAST = PSW'(PRESC - 1);

  logic [PSW-1:0] psc;
  logic [PW-1:0]  cnt;
  logic           tick;
  logic           wrap;

  assign tick = cen && (psc == PSC_LAST);
  // >= rather than == so a period shrunk below cnt wraps at once instead of rolling over 2^PW
  assign wrap = (period <= PW'(1)) || (cnt >= period - PW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc  <= '0;
      cnt  <= '0;
      step <= 1'b0;
    end else if (clr) begin
      psc  <= '0;
      cnt  <= '0;
      step <= 1'b0;
    end else if (cen) begin
      psc <= (psc == PSC_LAST) ? '0 : psc + PSW'(1);
      if (tick) begin
        if (wrap) begin
          cnt  <= '0;
          step <= ~step;
        end else begin
          cnt <= cnt + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/jt49_eg_sched.sv
// Envelope scheduler: R11/R12 period and R13 shape registers, step divider and restart handshake.
// Optional readback of the envelope registers on dout when JT49_EG_READBACK_EN is defined.
module jt49_eg_sched
  import jt49_pkg::*;
#(
  parameter int PW    = 16,
  parameter int PRESC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       wr_n,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       step,
  output logic       null_period,
  output logic       restart,
  output logic [3:0] ctrl
);

  logic [PW-1:0] period;
  logic [PW-1:0] period_nx;
  logic          wr_fine;
  logic          wr_coarse;
  logic          wr_shape;
  jt49_eg_st_e   st;
  jt49_eg_st_e   st_nx;
  logic          queued;
  logic          queued_nx;
  logic          fire;

  assign wr_fine   = !wr_n && (addr == JT49_REG_EFINE);
  assign wr_coarse = !wr_n && (addr == JT49_REG_ECOARSE);
  assign wr_shape  = !wr_n && (addr == JT49_REG_ESHAPE);

  always_comb begin
    period_nx = period;
    if (wr_fine) begin
      period_nx = (period & ~PW'(8'hFF)) | PW'(din);
    end else if (wr_coarse) begin
      period_nx = (period & PW'(8'hFF)) | PW'({din, 8'h00});
    end
  end

  // Register writes bypass cen so no CPU access is ever dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period      <= '0;
      ctrl        <= 4'h0;
      null_period <= 1'b1;
    end else begin
      period      <= period_nx;
      null_period <= (period_nx == '0);
      if (wr_shape) ctrl <= din[3:0];
    end
  end

  // A write seen while a restart is already in flight is queued so pulses never merge
  always_comb begin
    st_nx     = st;
    queued_nx = queued;
    fire      = 1'b0;
    case (st)
      IDLE: begin
        queued_nx = 1'b0;
        if (wr_shape) st_nx = PEND;
      end
      PEND: begin
        queued_nx = queued | wr_shape;
        if (cen) begin
          fire  = 1'b1;
          st_nx = FIRE;
        end
      end
      FIRE: begin
        queued_nx = 1'b0;
        st_nx     = (queued || wr_shape) ? PEND : IDLE;
      end
      default: begin
        queued_nx = 1'b0;
        st_nx     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      queued  <= 1'b0;
      restart <= 1'b0;
    end else begin
      st      <= st_nx;
      queued  <= queued_nx;
      restart <= fire;
    end
  end

  jt49_eg_cnt #(
    .PW    (PW),
    .PRESC (PRESC)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .period (period),
    .clr    (fire),
    .step   (step)
  );

`ifdef JT49_EG_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 8'h00;
    end else begin
      case (addr)
        JT49_REG_EFINE:   dout <= period[7:0];
        JT49_REG_ECOARSE: dout <= 8'(16'(period) >> 8);
        JT49_REG_ESHAPE:  dout <= {4'b0000, ctrl};
        default:          dout <= 8'h00;
      endcase
    end
  end
`else
  assign dout = 8'h00;
`endif

endmodule

// File: tb/tb_jt49_eg_sched.sv
// Self-checking bench for jt49_eg_sched: directed table, corner sequences and a randomized run
// against a tick-level reference model, on two parameterisations (PW=12/PRESC=1, PW=8/PRESC=2).
module tb_jt49_eg_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       wr_n = 1'b1;
  logic [3:0] addr = 4'd0;
  logic [7:0] din = 8'd0;

  logic [7:0] dout0, dout1;
  logic       step0, step1, null0, null1, rst0, rst1;
  logic [3:0] ctrl0, ctrl1;

  always #5 clk = ~clk;

  jt49_eg_sched #(.PW(12), .PRESC(1)) u0 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wr_n(wr_n), .addr(addr), .din(din),
    .dout(dout0), .step(step0), .null_period(null0), .restart(rst0), .ctrl(ctrl0)
  );

  jt49_eg_sched #(.PW(8), .PRESC(2)) u1 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wr_n(wr_n), .addr(addr), .din(din),
    .dout(dout1), .step(step1), .null_period(null1), .restart(rst1), .ctrl(ctrl1)
  );

  int checks = 0;
  int errors = 0;

  localparam int PRS [2] = '{1, 2};
  localparam int MSK [2] = '{32'hFFF, 32'hFF};

  // Reference model state: ticks since last toggle, outstanding restart requests
  int m_period[2], m_phase[2], m_psc[2], m_avail[2], m_ctrl[2], m_dout[2];
  bit m_step[2], m_rst[2], m_null[2];
  bit model_on = 1'b0;

  typedef struct {
    bit         cen;
    bit         wr;
    logic [3:0] addr;
    logic [7:0] din;
    bit         e_step;
    bit         e_rst;
    bit         e_null;
    logic [3:0] e_ctrl;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(bit c, bit w, logic [3:0] a, logic [7:0] d,
                              bit es, bit er, bit en, logic [3:0] ec);
    vec_t v;
    v.cen = c; v.wr = w; v.addr = a; v.din = d;
    v.e_step = es; v.e_rst = er; v.e_null = en; v.e_ctrl = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_period[i] = 0; m_phase[i] = 0; m_psc[i] = 0; m_avail[i] = 0;
      m_ctrl[i] = 0; m_dout[i] = 0; m_step[i] = 0; m_rst[i] = 0; m_null[i] = 1;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int  eff;
      bit  tick, fire;
      eff  = (m_period[i] > 1) ? m_period[i] : 1;
      tick = cen && (m_psc[i] == PRS[i] - 1);
      fire = (m_avail[i] > 0) && cen && !m_rst[i];
`ifdef JT49_EG_READBACK_EN
      case (addr)
        4'd11:   m_dout[i] = m_period[i] & 255;
        4'd12:   m_dout[i] = (m_period[i] >> 8) & 255;
        4'd13:   m_dout[i] = m_ctrl[i];
        default: m_dout[i] = 0;
      endcase
`else
      m_dout[i] = 0;
`endif
      if (cen) m_psc[i] = (m_psc[i] == PRS[i] - 1) ? 0 : m_psc[i] + 1;
      if (tick) begin
        if (m_phase[i] + 1 >= eff) begin
          m_phase[i] = 0;
          m_step[i]  = !m_step[i];
        end else begin
          m_phase[i]++;
        end
      end
      if (fire) begin
        m_phase[i] = 0; m_psc[i] = 0; m_step[i] = 0; m_avail[i]--;
      end
      m_rst[i] = fire;
      if (!wr_n) begin
        case (addr)
          4'd11: m_period[i] = ((m_period[i] & ~255) | int'(din)) & MSK[i];
          4'd12: m_period[i] = ((m_period[i] & 255) | (int'(din) << 8)) & MSK[i];
          4'd13: begin m_ctrl[i] = din & 15; m_avail[i]++; end
          default: ;
        endcase
      end
      m_null[i] = (m_period[i] == 0);
    end
  endtask

  task automatic compare();
    chk("step0", step0, m_step[0]);   chk("step1", step1, m_step[1]);
    chk("restart0", rst0, m_rst[0]);  chk("restart1", rst1, m_rst[1]);
    chk("null0", null0, m_null[0]);   chk("null1", null1, m_null[1]);
    chk("ctrl0", ctrl0, m_ctrl[0]);   chk("ctrl1", ctrl1, m_ctrl[1]);
    chk("dout0", dout0, m_dout[0]);   chk("dout1", dout1, m_dout[1]);
  endtask

  task automatic cyc(input bit c, input bit w, input logic [3:0] a, input logic [7:0] d);
    cen = c; wr_n = !w; addr = a; din = d;
    @(posedge clk);
    if (model_on) model_edge();
    #1;
    if (model_on) compare();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_step0"}, step0, 0);  chk({tag, "_step1"}, step1, 0);
    chk({tag, "_rst0"}, rst0, 0);    chk({tag, "_rst1"}, rst1, 0);
    chk({tag, "_ctrl0"}, ctrl0, 0);  chk({tag, "_ctrl1"}, ctrl1, 0);
    chk({tag, "_null0"}, null0, 1);  chk({tag, "_null1"}, null1, 1);
    chk({tag, "_dout0"}, dout0, 0);  chk({tag, "_dout1"}, dout1, 0);
  endtask

  initial begin
    int          rises[$];
    int          n;
    bit          s0, s1, found, w, c;
    logic [3:0]  a;
    logic [7:0]  d;
    int          sel;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table on u0: R13 write held off by cen=0, then back-to-back R13 writes
    tbl[0]  = mk(0, 0, 4'd0,  8'h00, 0, 0, 1, 4'h0);
    tbl[1]  = mk(0, 1, 4'd13, 8'h0E, 0, 0, 1, 4'hE);
    tbl[2]  = mk(0, 0, 4'd0,  8'h00, 0, 0, 1, 4'hE);
    tbl[3]  = mk(0, 0, 4'd0,  8'h00, 0, 0, 1, 4'hE);
    tbl[4]  = mk(0, 0, 4'd0,  8'h00, 0, 0, 1, 4'hE);
    tbl[5]  = mk(0, 0, 4'd0,  8'h00, 0, 0, 1, 4'hE);
    tbl[6]  = mk(1, 0, 4'd0,  8'h00, 0, 1, 1, 4'hE);
    tbl[7]  = mk(1, 0, 4'd0,  8'h00, 1, 0, 1, 4'hE);
    tbl[8]  = mk(1, 0, 4'd0,  8'h00, 0, 0, 1, 4'hE);
    tbl[9]  = mk(1, 0, 4'd0,  8'h00, 1, 0, 1, 4'hE);
    tbl[10] = mk(1, 1, 4'd13, 8'h01, 0, 0, 1, 4'h1);
    tbl[11] = mk(1, 1, 4'd13, 8'h0A, 0, 1, 1, 4'hA);
    tbl[12] = mk(1, 0, 4'd0,  8'h00, 1, 0, 1, 4'hA);
    tbl[13] = mk(1, 0, 4'd0,  8'h00, 0, 1, 1, 4'hA);
    tbl[14] = mk(1, 0, 4'd0,  8'h00, 1, 0, 1, 4'hA);
    tbl[15] = mk(1, 0, 4'd0,  8'h00, 0, 0, 1, 4'hA);
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].cen, tbl[i].wr, tbl[i].addr, tbl[i].din);
      chk($sformatf("tbl%0d_step", i), step0, tbl[i].e_step);
      chk($sformatf("tbl%0d_restart", i), rst0, tbl[i].e_rst);
      chk($sformatf("tbl%0d_null", i), null0, tbl[i].e_null);
      chk($sformatf("tbl%0d_ctrl", i), ctrl0, tbl[i].e_ctrl);
    end

    // Asynchronous reset with a restart pending: immediate clear, request discarded
    cyc(0, 1, 4'd13, 8'h05);
    cen = 1'b0; wr_n = 1'b1; addr = 4'd0; din = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_on = 1'b1;
    cyc(1, 0, 4'd0, 8'h00);
    cyc(1, 0, 4'd0, 8'h00);

    // Period 4 with PRESC=1: step rising edges 8 clk apart
    cyc(1, 1, 4'd11, 8'h04);
    cyc(1, 1, 4'd12, 8'h00);
    chk("period_null0", null0, 0);
    for (int k = 0; k < 60 && rises.size() < 3; k++) begin
      s0 = step0;
      cyc(1, 0, 4'd0, 8'h00);
      if (!s0 && step0) rises.push_back(k);
    end
    if (rises.size() >= 3) begin
      chk("period_rise_gap_a", rises[1] - rises[0], 8);
      chk("period_rise_gap_b", rises[2] - rises[1], 8);
    end else begin
      chk("period_rises", rises.size(), 3);
    end

    // Shrink period from 100 to 10 while the counter sits at 60
    cyc(1, 1, 4'd11, 8'd100);
    cyc(1, 1, 4'd13, 8'h00);
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (m_phase[0] == 60 && !m_rst[0] && m_avail[0] == 0) begin
        found = 1'b1;
        break;
      end
      cyc(1, 0, 4'd0, 8'h00);
    end
    chk("shrink_reached_60", found, 1);
    s0 = step0;
    cyc(1, 1, 4'd11, 8'd10);
    chk("shrink_hold", step0, s0);
    cyc(1, 0, 4'd0, 8'h00);
    chk("shrink_wrap", step0, !s0);
    s1 = step0;
    n = 0;
    do begin
      cyc(1, 0, 4'd0, 8'h00);
      n++;
    end while (step0 == s1 && n < 30);
    chk("shrink_interval", n, 10);

    // Coarse readback with PW=12: upper din bits dropped
    cyc(1, 1, 4'd12, 8'hA5);
    cyc(1, 0, 4'd12, 8'h00);
`ifdef JT49_EG_READBACK_EN
    chk("readback_coarse_pw12", dout0, 8'h05);
`else
    chk("readback_off_dout0", dout0, 8'h00);
`endif
    chk("readback_coarse_pw8", dout1, 8'h00);
    cyc(1, 1, 4'd12, 8'h00);

    // Randomized run against the model
    for (int k = 0; k < 3000; k++) begin
      c   = ($urandom % 10) < 6;
      w   = ($urandom % 4) == 0;
      sel = $urandom % 8;
      case (sel)
        0, 1, 2: a = 4'd11;
        3:       a = 4'd12;
        4, 5:    a = 4'd13;
        default: a = 4'($urandom_range(0, 10));
      endcase
      if (w && a == 4'd13 && (m_avail[0] != 0 || m_avail[1] != 0)) a = 4'd11;
      case (a)
        4'd11:   d = 8'($urandom % 16);
        4'd12:   d = (($urandom % 4) == 0) ? 8'hF0 : 8'h00;
        default: d = 8'($urandom);
      endcase
      cyc(c, w, a, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
